// File: rtl/icache_refill_responder_pkg.sv
// Shared types and geometry helpers for the I-cache refill responder.
// The state enum and the block/beat geometry are derived here from
// CACHE_WIDTH, MEM_WIDTH and SIZE_PC, so the top and assembler agree on them.
package icache_refill_responder_pkg;

    localparam int unsigned DEF_SIZE_PC     = 32;
    localparam int unsigned DEF_CACHE_WIDTH = 256;
    localparam int unsigned DEF_MEM_WIDTH   = 64;
    localparam int unsigned DEF_CNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL,
        ST_HOLD
    } refill_state_e;

    // Bytes per I-cache block (BLOCK_BYTES).
    function automatic int unsigned block_bytes(input int unsigned cache_width);
        return cache_width / 8;
    endfunction

    // Memory beats per block (BEATS); must be a power of two, at least 2.
    function automatic int unsigned beats(input int unsigned cache_width,
                                          input int unsigned mem_width);
        return cache_width / mem_width;
    endfunction

    // Bytes per memory beat (BEAT_BYTES).
    function automatic int unsigned beat_bytes(input int unsigned mem_width);
        return mem_width / 8;
    endfunction

    // Mask of the byte-offset-within-block address bits.
    function automatic logic [63:0] block_off_mask(input int unsigned cache_width);
        return 64'(block_bytes(cache_width) - 1);
    endfunction

endpackage

// File: rtl/icache_refill_responder_assembler.sv
// refill_block_assembler: collects memory beats into a cache block.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears everything)
//   beat_wr_i       - write beat_data_i into slot beat_idx_i (beat 0 = LSBs)
//   commit_i        - publish the block (including this cycle's beat) to block_o
//   beat_idx_i      - beat slot index
//   beat_data_i     - beat payload
//   block_o         - last committed block; holds between commits
module refill_block_assembler #(
    parameter int unsigned CACHE_WIDTH = 256,
    parameter int unsigned MEM_WIDTH   = 64,
    parameter int unsigned BEATS       = 4,
    parameter int unsigned BEAT_W      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat_wr_i,
    input  logic                   commit_i,
    input  logic [BEAT_W-1:0]      beat_idx_i,
    input  logic [MEM_WIDTH-1:0]   beat_data_i,
    output logic [CACHE_WIDTH-1:0] block_o
);

    logic [BEATS-1:0][MEM_WIDTH-1:0] work_q, work_d;
    logic [CACHE_WIDTH-1:0]          block_q;

    // Insert the incoming beat into its slot.
    always_comb begin
        work_d = work_q;
        if (beat_wr_i) begin
            work_d[beat_idx_i] = beat_data_i;
        end
    end

    // Working buffer is private so the published block only changes on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q  <= '0;
            block_q <= '0;
        end else begin
            work_q <= work_d;
            if (commit_i) begin
                block_q <= work_d;
            end
        end
    end

    assign block_o = block_q;

endmodule

// File: rtl/icache_refill_responder.sv
// icache_refill_responder: services an L1 I-cache miss by reading the aligned
// block from backing memory in MEM_WIDTH beats and writing it back to the
// I-cache in one cycle.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   miss_i, missAddr_i          - miss level and byte address (sampled in IDLE only)
//   wrEnable_o/wrAddr_o/instBlock_o - one-cycle block write to the I-cache
//   memReq_o/memAddr_o/memGnt_i - beat read request handshake
//   memRdValid_i/memRdData_i    - beat read return (accepted in WAIT only)
//   busy_o                      - not in IDLE
//   fillCount_o                 - completed fills, saturating
module icache_refill_responder
    import icache_refill_responder_pkg::*;
#(
    parameter int unsigned SIZE_PC     = DEF_SIZE_PC,
    parameter int unsigned CACHE_WIDTH = DEF_CACHE_WIDTH,
    parameter int unsigned MEM_WIDTH   = DEF_MEM_WIDTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_i,
    input  logic [SIZE_PC-1:0]     missAddr_i,
    output logic                   wrEnable_o,
    output logic [SIZE_PC-1:0]     wrAddr_o,
    output logic [CACHE_WIDTH-1:0] instBlock_o,
    output logic                   memReq_o,
    output logic [SIZE_PC-1:0]     memAddr_o,
    input  logic                   memGnt_i,
    input  logic                   memRdValid_i,
    input  logic [MEM_WIDTH-1:0]   memRdData_i,
    output logic                   busy_o,
    output logic [CNT_WIDTH-1:0]   fillCount_o
);

    localparam int unsigned BEATS      = beats(CACHE_WIDTH, MEM_WIDTH);
    localparam int unsigned BEAT_W     = $clog2(BEATS);
    localparam int unsigned BEAT_SHIFT = $clog2(beat_bytes(MEM_WIDTH));
    localparam logic [SIZE_PC-1:0] OFF_MASK  = SIZE_PC'(block_off_mask(CACHE_WIDTH));
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

    refill_state_e        state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [SIZE_PC-1:0]   blk_addr_q, blk_addr_d;
    logic                 mem_req_q, mem_req_d;
    logic [SIZE_PC-1:0]   mem_addr_q, mem_addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [SIZE_PC-1:0]   wr_addr_q, wr_addr_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                 beat_wr;
    logic                 commit;

    // Next-state and registered-output decode; outputs reflect the state being entered.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        blk_addr_d = blk_addr_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        fill_cnt_d = fill_cnt_q;
        beat_wr    = 1'b0;
        commit     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (miss_i) begin
                    blk_addr_d = missAddr_i & ~OFF_MASK;
                    beat_d     = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // Valid data in the grant cycle is deliberately not captured.
                if (memGnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (memRdValid_i) begin
                    beat_wr = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        commit    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = blk_addr_q;
                        state_d   = ST_FILL;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_FILL: begin
                if (fill_cnt_q != '1) begin
                    fill_cnt_d = fill_cnt_q + CNT_WIDTH'(1);
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Swallows the stale miss while L1 re-looks up the new block.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Request and address are set on REQ entry and held unchanged through REQ.
        if (state_d == ST_REQ) begin
            mem_req_d  = 1'b1;
            mem_addr_d = blk_addr_d + (SIZE_PC'(beat_d) << BEAT_SHIFT);
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            blk_addr_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            busy_q     <= 1'b0;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            blk_addr_q <= blk_addr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            busy_q     <= busy_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    refill_block_assembler #(
        .CACHE_WIDTH (CACHE_WIDTH),
        .MEM_WIDTH   (MEM_WIDTH),
        .BEATS       (BEATS),
        .BEAT_W      (BEAT_W)
    ) u_assembler (
        .clk         (clk),
        .reset       (reset),
        .beat_wr_i   (beat_wr),
        .commit_i    (commit),
        .beat_idx_i  (beat_q),
        .beat_data_i (memRdData_i),
        .block_o     (instBlock_o)
    );

    assign wrEnable_o  = wr_en_q;
    assign wrAddr_o    = wr_addr_q;
    assign memReq_o    = mem_req_q;
    assign memAddr_o   = mem_addr_q;
    assign busy_o      = busy_q;
    assign fillCount_o = fill_cnt_q;

endmodule

// File: tb/tb_icache_refill_responder.sv
// Self-checking bench for icache_refill_responder: a memory responder with
// per-beat grant/valid delays, an output monitor, and a block-level model.
module tb_icache_refill_responder;

    localparam int unsigned BEATS = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss_i;
    logic [31:0]  missAddr_i;
    logic         wrEnable_o;
    logic [31:0]  wrAddr_o;
    logic [255:0] instBlock_o;
    logic         memReq_o;
    logic [31:0]  memAddr_o;
    logic         memGnt_i;
    logic         memRdValid_i;
    logic [63:0]  memRdData_i;
    logic         busy_o;
    logic [15:0]  fillCount_o;

    icache_refill_responder dut (
        .clk          (clk),
        .reset        (reset),
        .miss_i       (miss_i),
        .missAddr_i   (missAddr_i),
        .wrEnable_o   (wrEnable_o),
        .wrAddr_o     (wrAddr_o),
        .instBlock_o  (instBlock_o),
        .memReq_o     (memReq_o),
        .memAddr_o    (memAddr_o),
        .memGnt_i     (memGnt_i),
        .memRdValid_i (memRdValid_i),
        .memRdData_i  (memRdData_i),
        .busy_o       (busy_o),
        .fillCount_o  (fillCount_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int exp_fills = 0;

    // Memory behaviour knobs.
    int          gnt_dly[BEATS];
    int          val_dly[BEATS];
    bit          spurious_en = 1'b0;
    int          data_mode = 0;
    logic [63:0] seed = 64'h0;

    // Logs.
    logic [31:0]  addr_log[$];
    int           wr_cyc_q[$];
    logic [31:0]  wr_addr_q[$];
    logic [255:0] wr_blk_q[$];
    int           req_log[$];
    int           unstable = 0;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (data_mode == 0) return 64'(a[4:3]);
        return {a ^ seed[31:0], ~a + seed[63:32]};
    endfunction

    function automatic logic [255:0] exp_block(input logic [31:0] blk);
        logic [255:0] r;
        for (int b = 0; b < BEATS; b++) r[b*64 +: 64] = mem_word(blk + 32'(b * 8));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_delays();
        for (int i = 0; i < BEATS; i++) begin
            gnt_dly[i] = 0;
            val_dly[i] = 0;
        end
    endtask

    // Memory responder: grant after gnt_dly cycles of request, data after val_dly WAIT cycles.
    initial begin
        int phase = 0;
        int gcnt = 0;
        int vcnt = 0;
        bit pending = 1'b0;
        logic [31:0] g_addr = 32'h0;
        memGnt_i = 1'b0;
        memRdValid_i = 1'b0;
        memRdData_i = '0;
        forever begin
            tick();
            memGnt_i = 1'b0;
            memRdValid_i = 1'b0;
            memRdData_i = '0;
            if (reset) begin
                phase = 0; gcnt = 0; vcnt = 0; pending = 1'b0;
            end else if (phase == 0) begin
                if (spurious_en) begin
                    memRdValid_i = 1'b1;
                    memRdData_i = 64'hDEAD;
                end
                if (memReq_o) begin
                    if (pending && memAddr_o !== g_addr) unstable++;
                    pending = 1'b1;
                    g_addr = memAddr_o;
                    if (gcnt >= gnt_dly[memAddr_o[4:3]]) begin
                        memGnt_i = 1'b1;
                        addr_log.push_back(memAddr_o);
                        phase = 1; gcnt = 0; vcnt = 0; pending = 1'b0;
                    end else begin
                        gcnt++;
                    end
                end else if (pending) begin
                    unstable++;
                    pending = 1'b0;
                end
            end else begin
                if (vcnt >= val_dly[g_addr[4:3]]) begin
                    memRdValid_i = 1'b1;
                    memRdData_i = mem_word(g_addr);
                    phase = 0;
                end else begin
                    vcnt++;
                end
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (wrEnable_o === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(wrAddr_o);
            wr_blk_q.push_back(instBlock_o);
        end
        if (memReq_o === 1'b1 && !prev_req) req_log.push_back(cyc);
        prev_req = (memReq_o === 1'b1);
    end

    // Issue one miss (held for 'hold' cycles, then address switched) and run to IDLE.
    task automatic do_refill(input logic [31:0] a, input int hold, input logic [31:0] after_a,
                             output int t0, output bit ok);
        int n0 = wr_cyc_q.size();
        int k = 0;
        addr_log.delete();
        req_log.delete();
        miss_i = 1'b1;
        missAddr_i = a;
        t0 = cyc;
        while (k < 300 && !(wr_cyc_q.size() > n0 && k >= hold && busy_o === 1'b0)) begin
            tick();
            k++;
            if (k == hold) begin
                miss_i = 1'b0;
                missAddr_i = after_a;
            end
        end
        ok = (k < 300);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        miss_i = 1'b0;
        missAddr_i = '0;
        repeat (3) tick();
        total++; if (wrEnable_o !== 1'b0 || memReq_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: wr=%b req=%b busy=%b want 0", wrEnable_o, memReq_o, busy_o);
        end
        total++; if (wrAddr_o !== 32'h0 || memAddr_o !== 32'h0) begin
            bad++; $display("FAIL reset_addr: wrAddr=%h memAddr=%h want 0", wrAddr_o, memAddr_o);
        end
        total++; if (instBlock_o !== 256'h0 || fillCount_o !== 16'h0) begin
            bad++; $display("FAIL reset_data: block=%h cnt=%0d want 0", instBlock_o, fillCount_o);
        end
        reset = 1'b0;
        exp_fills = 0;
        tick();
    endtask

    task automatic test_zero_wait();
        int t0; bit ok; int n0;
        logic [255:0] want_blk;
        logic [31:0] want_a[4];
        want_blk = {64'h3, 64'h2, 64'h1, 64'h0};
        want_a = '{32'h1220, 32'h1228, 32'h1230, 32'h1238};
        clear_delays(); data_mode = 0; spurious_en = 1'b0; unstable = 0;
        n0 = wr_cyc_q.size();
        do_refill(32'h0000_1234, 1, 32'h0, t0, ok);
        exp_fills++;
        total++; if (!ok) begin bad++; $display("FAIL zw_timeout: refill did not finish"); end
        total++; if (wr_cyc_q.size() != n0 + 1) begin
            bad++; $display("FAIL zw_pulses: got %0d want 1", wr_cyc_q.size() - n0);
        end else begin
            total++; if (wr_cyc_q[n0] != t0 + 9) begin
                bad++; $display("FAIL zw_latency: got cycle %0d want %0d", wr_cyc_q[n0] - t0, 9);
            end
            total++; if (wr_addr_q[n0] !== 32'h1220) begin
                bad++; $display("FAIL zw_wraddr: got %h want 00001220", wr_addr_q[n0]);
            end
            total++; if (wr_blk_q[n0] !== want_blk) begin
                bad++; $display("FAIL zw_block: got %h want %h", wr_blk_q[n0], want_blk);
            end
        end
        total++; if (addr_log.size() != 4) begin
            bad++; $display("FAIL zw_nreq: got %0d want 4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (addr_log[i] !== want_a[i]) begin
                    bad++; $display("FAIL zw_memaddr%0d: got %h want %h", i, addr_log[i], want_a[i]);
                end
            end
        end
        total++; if (fillCount_o !== 16'(exp_fills)) begin
            bad++; $display("FAIL zw_count: got %0d want %0d", fillCount_o, exp_fills);
        end
    endtask

    task automatic test_delayed();
        int t0; bit ok; int n0;
        logic [255:0] want_blk;
        want_blk = {64'h3, 64'h2, 64'h1, 64'h0};
        clear_delays(); data_mode = 0; unstable = 0;
        gnt_dly[1] = 3; val_dly[2] = 2;
        n0 = wr_cyc_q.size();
        do_refill(32'h0000_1234, 1, 32'h0, t0, ok);
        exp_fills++;
        total++; if (!ok || wr_cyc_q.size() != n0 + 1) begin
            bad++; $display("FAIL dly_pulses: ok=%0d got %0d want 1", ok, wr_cyc_q.size() - n0);
        end else begin
            total++; if (wr_cyc_q[n0] != t0 + 14) begin
                bad++; $display("FAIL dly_latency: got cycle %0d want 14", wr_cyc_q[n0] - t0);
            end
            total++; if (wr_blk_q[n0] !== want_blk || wr_addr_q[n0] !== 32'h1220) begin
                bad++; $display("FAIL dly_block: got %h@%h want %h@00001220", wr_blk_q[n0], wr_addr_q[n0], want_blk);
            end
        end
        total++; if (unstable != 0) begin
            bad++; $display("FAIL dly_req_stable: got %0d changes want 0", unstable);
        end
        clear_delays();
    endtask

    task automatic test_back_to_back();
        int t0; int n0; int nxt;
        clear_delays(); data_mode = 0;
        n0 = wr_cyc_q.size();
        req_log.delete();
        miss_i = 1'b1; missAddr_i = 32'h0000_1234; t0 = cyc;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 12) miss_i = 1'b0;
        end
        exp_fills += 2;
        total++; if (wr_cyc_q.size() != n0 + 2) begin
            bad++; $display("FAIL b2b_pulses: got %0d want 2", wr_cyc_q.size() - n0);
        end else begin
            total++; if (wr_cyc_q[n0] != t0 + 9 || wr_cyc_q[n0+1] != t0 + 20) begin
                bad++; $display("FAIL b2b_timing: got %0d,%0d want 9,20", wr_cyc_q[n0] - t0, wr_cyc_q[n0+1] - t0);
            end
        end
        nxt = -1;
        foreach (req_log[i]) if (nxt < 0 && req_log[i] > t0 + 9) nxt = req_log[i];
        total++; if (nxt != t0 + 12) begin
            bad++; $display("FAIL b2b_next_req: got cycle %0d want 12", nxt - t0);
        end
        total++; if (fillCount_o !== 16'(exp_fills)) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d", fillCount_o, exp_fills);
        end
    endtask

    task automatic test_redirect();
        int t0; bit ok; int n0; int rq0;
        clear_delays(); data_mode = 0;
        n0 = wr_cyc_q.size();
        do_refill(32'h0000_1234, 4, 32'h0000_4000, t0, ok);
        exp_fills++;
        rq0 = req_log.size();
        repeat (10) tick();
        total++; if (!ok || wr_cyc_q.size() != n0 + 1) begin
            bad++; $display("FAIL redir_pulses: ok=%0d got %0d want 1", ok, wr_cyc_q.size() - n0);
        end else begin
            total++; if (wr_addr_q[n0] !== 32'h1220) begin
                bad++; $display("FAIL redir_addr: got %h want 00001220", wr_addr_q[n0]);
            end
        end
        total++; if (req_log.size() != rq0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL redir_idle: got %0d new reqs busy=%b want 0", req_log.size() - rq0, busy_o);
        end
    endtask

    task automatic test_spurious();
        int t0; bit ok; int n0;
        logic [255:0] want_blk;
        want_blk = {64'h3, 64'h2, 64'h1, 64'h0};
        clear_delays(); data_mode = 0;
        gnt_dly[0] = 2;
        spurious_en = 1'b1;
        repeat (3) tick();
        n0 = wr_cyc_q.size();
        do_refill(32'h0000_1234, 1, 32'h0, t0, ok);
        spurious_en = 1'b0;
        exp_fills++;
        total++; if (!ok || wr_cyc_q.size() != n0 + 1) begin
            bad++; $display("FAIL spur_pulses: ok=%0d got %0d want 1", ok, wr_cyc_q.size() - n0);
        end else begin
            total++; if (wr_blk_q[n0] !== want_blk) begin
                bad++; $display("FAIL spur_block: got %h want %h", wr_blk_q[n0], want_blk);
            end
            total++; if (wr_cyc_q[n0] != t0 + 11) begin
                bad++; $display("FAIL spur_latency: got cycle %0d want 11", wr_cyc_q[n0] - t0);
            end
        end
        total++; if (addr_log.size() != 4 || addr_log[0] !== 32'h1220 || addr_log[3] !== 32'h1238) begin
            bad++; $display("FAIL spur_beats: got %0d reqs first %h", addr_log.size(), addr_log[0]);
        end
        clear_delays();
    endtask

    task automatic test_reset_mid();
        int t0; bit ok; int n0;
        logic [31:0] a; logic [31:0] blk;
        clear_delays(); data_mode = 0;
        n0 = wr_cyc_q.size();
        miss_i = 1'b1; missAddr_i = 32'h0000_1234; t0 = cyc;
        tick();
        miss_i = 1'b0;
        while (cyc < t0 + 6) tick();
        reset = 1'b1;
        tick();
        total++; if (wrEnable_o !== 1'b0 || memReq_o !== 1'b0 || busy_o !== 1'b0 ||
                     memAddr_o !== 32'h0 || wrAddr_o !== 32'h0) begin
            bad++; $display("FAIL rmid_ctl: wr=%b req=%b busy=%b ma=%h wa=%h want 0",
                            wrEnable_o, memReq_o, busy_o, memAddr_o, wrAddr_o);
        end
        total++; if (instBlock_o !== 256'h0 || fillCount_o !== 16'h0) begin
            bad++; $display("FAIL rmid_data: block=%h cnt=%0d want 0", instBlock_o, fillCount_o);
        end
        tick();
        reset = 1'b0;
        exp_fills = 0;
        repeat (15) tick();
        total++; if (wr_cyc_q.size() != n0) begin
            bad++; $display("FAIL rmid_nowrite: got %0d pulses want 0", wr_cyc_q.size() - n0);
        end
        data_mode = 1; seed = {$urandom, $urandom};
        a = $urandom;
        blk = {a[31:5], 5'b0};
        do_refill(a, 1, 32'h0, t0, ok);
        exp_fills++;
        total++; if (!ok || wr_cyc_q.size() != n0 + 1) begin
            bad++; $display("FAIL rmid_refill: ok=%0d got %0d pulses want 1", ok, wr_cyc_q.size() - n0);
        end else begin
            total++; if (wr_blk_q[n0] !== exp_block(blk) || wr_addr_q[n0] !== blk) begin
                bad++; $display("FAIL rmid_block: got %h@%h want %h@%h", wr_blk_q[n0], wr_addr_q[n0], exp_block(blk), blk);
            end
        end
        total++; if (addr_log.size() == 0 || addr_log[0] !== blk || fillCount_o !== 16'(exp_fills)) begin
            bad++; $display("FAIL rmid_beat0: reqs=%0d cnt=%0d want first %h cnt %0d", addr_log.size(), fillCount_o, blk, exp_fills);
        end
    endtask

    task automatic test_random();
        int t0; bit ok; int n0; int extra;
        logic [31:0] a; logic [31:0] blk;
        data_mode = 1;
        for (int it = 0; it < 16; it++) begin
            seed = {$urandom, $urandom};
            a = $urandom;
            blk = {a[31:5], 5'b0};
            extra = 0;
            for (int i = 0; i < BEATS; i++) begin
                gnt_dly[i] = int'($urandom_range(0, 3));
                val_dly[i] = int'($urandom_range(0, 3));
                extra += gnt_dly[i] + val_dly[i];
            end
            n0 = wr_cyc_q.size();
            do_refill(a, int'($urandom_range(1, 3)), $urandom, t0, ok);
            exp_fills++;
            total++; if (!ok || wr_cyc_q.size() != n0 + 1) begin
                bad++; $display("FAIL rnd%0d_pulses: ok=%0d got %0d want 1", it, ok, wr_cyc_q.size() - n0);
            end else begin
                total++; if (wr_cyc_q[n0] != t0 + 1 + 2 * BEATS + extra) begin
                    bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, wr_cyc_q[n0] - t0, 1 + 2 * BEATS + extra);
                end
                total++; if (wr_addr_q[n0] !== blk || wr_blk_q[n0] !== exp_block(blk)) begin
                    bad++; $display("FAIL rnd%0d_block: got %h@%h want %h@%h", it, wr_blk_q[n0], wr_addr_q[n0], exp_block(blk), blk);
                end
            end
            for (int i = 0; i < BEATS; i++) begin
                total++; if (i >= addr_log.size() || addr_log[i] !== blk + 32'(i * 8)) begin
                    bad++; $display("FAIL rnd%0d_memaddr%0d: want %h", it, i, blk + 32'(i * 8));
                end
            end
            total++; if (fillCount_o !== 16'(exp_fills)) begin
                bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, fillCount_o, exp_fills);
            end
        end
        clear_delays();
    endtask

    initial begin
        clear_delays();
        test_reset();
        test_zero_wait();
        test_delayed();
        test_back_to_back();
        test_redirect();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
